// File: rtl/irrigation_scheduler_if.sv
// Sample, abort and handshake signals between the greenhouse sensors/operator,
// the irrigation scheduler and the downstream cycle state machine.
interface irrigation_scheduler_if;
  logic       sample_valid;
  logic [7:0] moisture;
  logic [7:0] temperature;
  logic       manual_stop;
  logic       cycle_done;
  logic       enable;
  logic [7:0] state1_duration;
  logic [7:0] state2_duration;
  logic [7:0] state3_duration;
  logic       busy;
  logic       fault;
  logic [7:0] cycle_count;

  modport master (
    output sample_valid, moisture, temperature, manual_stop, cycle_done,
    input  enable, state1_duration, state2_duration, state3_duration,
           busy, fault, cycle_count
  );

  modport slave (
    input  sample_valid, moisture, temperature, manual_stop, cycle_done,
    output enable, state1_duration, state2_duration, state3_duration,
           busy, fault, cycle_count
  );
endinterface

// File: rtl/irrigation_scheduler.sv
// Decides when a watering/ventilation cycle is needed, sizes its phases and
// supervises the downstream cycle state machine (cooldown, abort, timeout).
module irrigation_scheduler #(
  parameter logic [7:0]  MOIST_THRESH    = 8'd100,
  parameter logic [7:0]  TEMP_THRESH     = 8'd30,
  parameter logic [7:0]  SETTLE_CYCLES   = 8'd4,
  parameter logic [15:0] COOLDOWN_CYCLES = 16'd8,
  parameter logic [15:0] TIMEOUT_CYCLES  = 16'd1024
) (
  input logic                   clk,
  input logic                   reset,
  irrigation_scheduler_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_COOL = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  dur1_q, dur1_d, dur2_q, dur2_d, dur3_q, dur3_d;
  logic [7:0]  count_q, count_d;
  logic        fault_q, fault_d;
  logic        enable_q, busy_q;
  logic        trigger;

  // Subtractions are guarded so a phase length never wraps or reaches zero.
  function automatic logic [7:0] moist_dur(input logic [7:0] m);
    return (m < MOIST_THRESH) ? (MOIST_THRESH - m) : 8'd1;
  endfunction

  function automatic logic [7:0] temp_dur(input logic [7:0] t);
    return (t > TEMP_THRESH) ? (t - TEMP_THRESH) : 8'd1;
  endfunction

  assign trigger = bus.sample_valid &&
                   ((bus.moisture < MOIST_THRESH) || (bus.temperature > TEMP_THRESH));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    dur1_d  = dur1_q;
    dur2_d  = dur2_q;
    dur3_d  = dur3_q;
    count_d = count_q;
    fault_d = fault_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (trigger) begin
          state_d = S_RUN;
          dur1_d  = moist_dur(bus.moisture);
          dur2_d  = SETTLE_CYCLES;
          dur3_d  = temp_dur(bus.temperature);
        end
      end
      S_RUN: begin
        if (bus.cycle_done) begin
          state_d = S_COOL;
          cnt_d   = '0;
          if (count_q != 8'hFF) count_d = count_q + 8'd1;
        end else if (bus.manual_stop) begin
          state_d = S_COOL;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_CYCLES - 16'd1) begin
          state_d = S_COOL;
          cnt_d   = '0;
          fault_d = 1'b1;
        end
      end
      S_COOL: begin
        // Lingering downstream done lands here and is deliberately ignored.
        if (cnt_q == COOLDOWN_CYCLES - 16'd1) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      dur1_q   <= 8'd1;
      dur2_q   <= 8'd1;
      dur3_q   <= 8'd1;
      count_q  <= '0;
      fault_q  <= 1'b0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dur1_q   <= dur1_d;
      dur2_q   <= dur2_d;
      dur3_q   <= dur3_d;
      count_q  <= count_d;
      fault_q  <= fault_d;
      enable_q <= (state_d == S_RUN);
      busy_q   <= (state_d != S_IDLE);
    end
  end

  assign bus.enable          = enable_q;
  assign bus.busy            = busy_q;
  assign bus.state1_duration = dur1_q;
  assign bus.state2_duration = dur2_q;
  assign bus.state3_duration = dur3_q;
  assign bus.cycle_count     = count_q;
  assign bus.fault           = fault_q;
endmodule
